// File: rtl/dlsc_pcie_s6_outbound_write_pkg.sv
// rtl/dlsc_pcie_s6_outbound_write_pkg.sv - shared encodings and helpers for the outbound write segmenter
package dlsc_pcie_s6_outbound_write_pkg;

    // max_payload_size encodings; anything at or above MPS_512 is treated as 512B
    localparam logic [2:0] MPS_128 = 3'd0;
    localparam logic [2:0] MPS_256 = 3'd1;
    localparam logic [2:0] MPS_512 = 3'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_DRAIN,
        ST_RESP
    } state_t;

    // payload limit in DWs for a given max_payload_size setting
    function automatic logic [7:0] mps_dw_limit(input logic [2:0] mps);
        case (mps)
            MPS_128: return 8'd32;
            MPS_256: return 8'd64;
            default: return 8'd128;
        endcase
    endfunction

endpackage

// File: rtl/dlsc_fifo.sv
// rtl/dlsc_fifo.sv - synchronous FIFO with up to two pushes per cycle and a registered-free head output
module dlsc_fifo #(
    parameter int DATA  = 32,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push_a,
    input  logic [DATA-1:0]           data_a,
    input  logic                      push_b,
    input  logic [DATA-1:0]           data_b,
    input  logic                      pop,
    output logic [DATA-1:0]           head,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr_b;
    logic            pop_ok;

    // entry b lands after entry a when both are pushed in the same cycle
    assign wr_ptr_b = wr_ptr + AW'(push_a);
    assign empty    = (count == '0);
    assign pop_ok   = pop && !empty;
    assign head     = mem[rd_ptr];

    // storage write; callers guarantee room before pushing
    always_ff @(posedge clk) begin
        if (push_a) mem[wr_ptr]   <= data_a;
        if (push_b) mem[wr_ptr_b] <= data_b;
    end

    // pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push_a) + AW'(push_b);
            rd_ptr <= rd_ptr + AW'(pop_ok);
            count  <= count + (AW+1)'(push_a) + (AW+1)'(push_b) - (AW+1)'(pop_ok);
        end
    end

endmodule

// File: rtl/dlsc_pcie_s6_outbound_write.sv
// rtl/dlsc_pcie_s6_outbound_write.sv - splits AXI write bursts into posted memory-write segments
module dlsc_pcie_s6_outbound_write
    import dlsc_pcie_s6_outbound_write_pkg::*;
#(
    parameter int ADDR       = 32,
    parameter int DATA_DEPTH = 128,
    parameter int HDR_DEPTH  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            axi_aw_ready,
    input  logic            axi_aw_valid,
    input  logic [ADDR-1:0] axi_aw_addr,
    input  logic [7:0]      axi_aw_len,
    output logic            axi_w_ready,
    input  logic            axi_w_valid,
    input  logic [31:0]     axi_w_data,
    input  logic [3:0]      axi_w_strb,
    input  logic            axi_w_last,
    input  logic            axi_b_ready,
    output logic            axi_b_valid,
    output logic [1:0]      axi_b_resp,
    input  logic [2:0]      max_payload_size,
    input  logic            wr_tlp_h_ready,
    output logic            wr_tlp_h_valid,
    output logic [ADDR-3:0] wr_tlp_h_addr,
    output logic [9:0]      wr_tlp_h_len,
    output logic [3:0]      wr_tlp_h_be_first,
    output logic [3:0]      wr_tlp_h_be_last,
    input  logic            wr_tlp_d_ready,
    output logic            wr_tlp_d_valid,
    output logic [31:0]     wr_tlp_d_data
);

    localparam int AW  = ADDR - 2;
    localparam int HW  = AW + 18;
    localparam int DAW = $clog2(DATA_DEPTH);
    localparam int HAW = $clog2(HDR_DEPTH);

    state_t          state;
    state_t          state_next;
    logic            rst_done;

    logic [AW-1:0]   addr;
    logic [AW-1:0]   next_addr;
    logic [AW-1:0]   seg_addr;
    logic [8:0]      beats_left;
    logic [7:0]      seg_len;
    logic [7:0]      seg_len_inc;
    logic [7:0]      mps_limit;
    logic            err;

    logic            aw_hs;
    logic            w_hs;
    logic            full_strb;
    logic            final_beat;
    logic            close_full;

    logic            d_empty;
    logic [DAW:0]    d_count;
    logic            d_room;
    logic            h_empty;
    logic [HAW:0]    h_count;
    logic            h_room1;
    logic            h_room2;
    logic [HW-1:0]   h_head;
    logic            h_push_a;
    logic            h_push_b;
    logic [HW-1:0]   h_data_a;
    logic [HW-1:0]   h_data_b;

    logic            unused_aw_lsb;
    assign unused_aw_lsb = ^axi_aw_addr[1:0];

    assign d_room  = (d_count != (DAW+1)'(DATA_DEPTH));
    assign h_room1 = (h_count != (HAW+1)'(HDR_DEPTH));
    assign h_room2 = (h_count <  (HAW+1)'(HDR_DEPTH - 1));

    assign aw_hs       = axi_aw_valid && axi_aw_ready;
    assign w_hs        = axi_w_valid && axi_w_ready;
    assign full_strb   = (axi_w_strb == 4'hF);
    assign final_beat  = (beats_left == 9'd1);
    assign next_addr   = addr + AW'(1);
    assign seg_len_inc = seg_len + 8'd1;
    assign close_full  = (seg_len_inc == mps_limit) || (next_addr[9:0] == 10'd0) || final_beat;

    // Header pushes: a full beat may close the running segment; a partial beat first flushes
    // any open segment (entry a) and then always stands alone as a 1-DW segment (entry b).
    assign h_push_a = w_hs && (full_strb ? close_full : (seg_len != 8'd0));
    assign h_push_b = w_hs && !full_strb;
    assign h_data_a = full_strb ?
        {seg_addr, 2'b00, seg_len_inc, 4'hF, (seg_len_inc == 8'd1) ? 4'h0 : 4'hF} :
        {seg_addr, 2'b00, seg_len,     4'hF, (seg_len     == 8'd1) ? 4'h0 : 4'hF};
    assign h_data_b = {addr, 10'd1, axi_w_strb, 4'h0};

    assign wr_tlp_h_valid    = !h_empty;
    assign wr_tlp_h_addr     = h_head[HW-1:18];
    assign wr_tlp_h_len      = h_head[17:8];
    assign wr_tlp_h_be_first = h_head[7:4];
    assign wr_tlp_h_be_last  = h_head[3:0];
    assign wr_tlp_d_valid    = !d_empty;

    // holds AW closed while reset is asserted even though the FSM sits in idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_done <= 1'b0;
        else        rst_done <= 1'b1;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // FSM next state and handshake outputs
    always_comb begin
        state_next   = state;
        axi_aw_ready = 1'b0;
        axi_w_ready  = 1'b0;
        axi_b_valid  = 1'b0;
        axi_b_resp   = RESP_OKAY;
        case (state)
            ST_IDLE: begin
                axi_aw_ready = rst_done;
                if (axi_aw_valid && rst_done) state_next = ST_DATA;
            end
            ST_DATA: begin
                axi_w_ready = d_room && h_room1 && (full_strb || h_room2);
                if (axi_w_valid && axi_w_ready && final_beat) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (d_empty) state_next = ST_RESP;
            end
            ST_RESP: begin
                axi_b_valid = 1'b1;
                axi_b_resp  = err ? RESP_SLVERR : RESP_OKAY;
                if (axi_b_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // burst address, beat count and open-segment tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr       <= '0;
            seg_addr   <= '0;
            beats_left <= '0;
            seg_len    <= '0;
            mps_limit  <= 8'd32;
            err        <= 1'b0;
        end else begin
            if (aw_hs) begin
                addr       <= axi_aw_addr[ADDR-1:2];
                seg_addr   <= axi_aw_addr[ADDR-1:2];
                beats_left <= {1'b0, axi_aw_len} + 9'd1;
                seg_len    <= '0;
                mps_limit  <= mps_dw_limit(max_payload_size);
                err        <= 1'b0;
            end
            if (w_hs) begin
                addr       <= next_addr;
                beats_left <= beats_left - 9'd1;
                if (axi_w_last != final_beat) err <= 1'b1;
                if (!full_strb || close_full) begin
                    seg_len  <= '0;
                    seg_addr <= next_addr;
                end else begin
                    seg_len  <= seg_len_inc;
                end
            end
        end
    end

    dlsc_fifo #(
        .DATA  (32),
        .DEPTH (DATA_DEPTH)
    ) u_data_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_a (w_hs),
        .data_a (axi_w_data),
        .push_b (1'b0),
        .data_b (32'd0),
        .pop    (wr_tlp_d_ready),
        .head   (wr_tlp_d_data),
        .empty  (d_empty),
        .count  (d_count)
    );

    dlsc_fifo #(
        .DATA  (HW),
        .DEPTH (HDR_DEPTH)
    ) u_hdr_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_a (h_push_a),
        .data_a (h_data_a),
        .push_b (h_push_b),
        .data_b (h_data_b),
        .pop    (wr_tlp_h_ready),
        .head   (h_head),
        .empty  (h_empty),
        .count  (h_count)
    );

endmodule

// File: tb/tb_dlsc_pcie_s6_outbound_write.sv
// tb/tb_dlsc_pcie_s6_outbound_write.sv - self-checking bench for the outbound write segmenter
module tb_dlsc_pcie_s6_outbound_write;

    localparam int ADDR       = 32;
    localparam int DATA_DEPTH = 128;
    localparam int HDR_DEPTH  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        axi_aw_ready, axi_aw_valid;
    logic [31:0] axi_aw_addr;
    logic [7:0]  axi_aw_len;
    logic        axi_w_ready, axi_w_valid, axi_w_last;
    logic [31:0] axi_w_data;
    logic [3:0]  axi_w_strb;
    logic        axi_b_ready, axi_b_valid;
    logic [1:0]  axi_b_resp;
    logic [2:0]  max_payload_size;
    logic        wr_tlp_h_ready, wr_tlp_h_valid;
    logic [29:0] wr_tlp_h_addr;
    logic [9:0]  wr_tlp_h_len;
    logic [3:0]  wr_tlp_h_be_first, wr_tlp_h_be_last;
    logic        wr_tlp_d_ready, wr_tlp_d_valid;
    logic [31:0] wr_tlp_d_data;

    dlsc_pcie_s6_outbound_write #(
        .ADDR(ADDR), .DATA_DEPTH(DATA_DEPTH), .HDR_DEPTH(HDR_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .axi_aw_ready(axi_aw_ready), .axi_aw_valid(axi_aw_valid),
        .axi_aw_addr(axi_aw_addr), .axi_aw_len(axi_aw_len),
        .axi_w_ready(axi_w_ready), .axi_w_valid(axi_w_valid),
        .axi_w_data(axi_w_data), .axi_w_strb(axi_w_strb), .axi_w_last(axi_w_last),
        .axi_b_ready(axi_b_ready), .axi_b_valid(axi_b_valid), .axi_b_resp(axi_b_resp),
        .max_payload_size(max_payload_size),
        .wr_tlp_h_ready(wr_tlp_h_ready), .wr_tlp_h_valid(wr_tlp_h_valid),
        .wr_tlp_h_addr(wr_tlp_h_addr), .wr_tlp_h_len(wr_tlp_h_len),
        .wr_tlp_h_be_first(wr_tlp_h_be_first), .wr_tlp_h_be_last(wr_tlp_h_be_last),
        .wr_tlp_d_ready(wr_tlp_d_ready), .wr_tlp_d_valid(wr_tlp_d_valid),
        .wr_tlp_d_data(wr_tlp_d_data)
    );

    typedef struct {
        logic [29:0] a;
        logic [9:0]  l;
        logic [3:0]  bf;
        logic [3:0]  bl;
    } hdr_t;

    hdr_t        exp_h[$];
    hdr_t        got_h[$];
    logic [31:0] exp_d[$];
    logic [31:0] got_d[$];
    logic [3:0]  strbs[$];

    int checks = 0;
    int errors = 0;
    int w_acc = 0;
    int stall_cnt = 0;
    int stall_fill = -1;
    bit stall = 0;
    bit rnd = 0;
    bit hold = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [47:0] pack(input hdr_t h);
        return {h.a, h.l, h.bf, h.bl};
    endfunction

    function automatic logic [47:0] got_pack(input int i);
        if (i < got_h.size()) return pack(got_h[i]);
        return 48'hFFFF_FFFF_FFFF;
    endfunction

    // Reference segmentation: walk the burst DW by DW, close on limit / 4KB boundary / end,
    // and isolate every partially-strobed beat into its own 1-DW segment.
    function automatic void model(input logic [31:0] a, input int len, input logic [2:0] mps);
        int          limit;
        int          n;
        logic [29:0] cur;
        logic [29:0] start;
        logic [29:0] nxt;
        hdr_t        h;
        limit = (mps == 3'd0) ? 32 : (mps == 3'd1) ? 64 : 128;
        cur   = a[31:2];
        start = cur;
        n     = 0;
        exp_h.delete();
        for (int i = 0; i <= len; i++) begin
            nxt = cur + 30'd1;
            if (strbs[i] != 4'hF) begin
                if (n > 0) begin
                    h.a = start; h.l = 10'(n); h.bf = 4'hF; h.bl = (n == 1) ? 4'h0 : 4'hF;
                    exp_h.push_back(h);
                end
                h.a = cur; h.l = 10'd1; h.bf = strbs[i]; h.bl = 4'h0;
                exp_h.push_back(h);
                n = 0;
                start = nxt;
            end else begin
                n++;
                if (n == limit || nxt[9:0] == 10'd0 || i == len) begin
                    h.a = start; h.l = 10'(n); h.bf = 4'hF; h.bl = (n == 1) ? 4'h0 : 4'hF;
                    exp_h.push_back(h);
                    n = 0;
                    start = nxt;
                end
            end
            cur = nxt;
        end
    endfunction

    // output collectors
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_tlp_h_valid && wr_tlp_h_ready)
                got_h.push_back('{wr_tlp_h_addr, wr_tlp_h_len, wr_tlp_h_be_first, wr_tlp_h_be_last});
            if (wr_tlp_d_valid && wr_tlp_d_ready)
                got_d.push_back(wr_tlp_d_data);
            if (axi_w_valid && axi_w_ready)
                w_acc++;
        end
    end

    // downstream ready generation: hold, fill-until-full stall, random, or always ready
    initial begin
        wr_tlp_h_ready = 1'b1;
        wr_tlp_d_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (hold) begin
                wr_tlp_h_ready = 1'b0;
                wr_tlp_d_ready = 1'b0;
            end else if (stall) begin
                wr_tlp_h_ready = 1'b1;
                wr_tlp_d_ready = 1'b0;
                if (axi_w_valid && !axi_w_ready) stall_cnt++;
                else stall_cnt = 0;
                if (stall_cnt >= 20) begin
                    stall_fill = w_acc;
                    stall = 0;
                    stall_cnt = 0;
                end
            end else if (rnd) begin
                wr_tlp_h_ready = ($urandom_range(0, 3) != 0);
                wr_tlp_d_ready = ($urandom_range(0, 3) != 0);
            end else begin
                wr_tlp_h_ready = 1'b1;
                wr_tlp_d_ready = 1'b1;
            end
        end
    end

    task automatic send_aw(input logic [31:0] a, input int len, input logic [2:0] mps);
        bit hs = 0;
        int t = 0;
        axi_aw_valid = 1'b1;
        axi_aw_addr = a;
        axi_aw_len = 8'(len);
        max_payload_size = mps;
        while (!hs && t < 100) begin
            @(negedge clk);
            hs = axi_aw_ready;
            tick();
            t++;
        end
        chk("aw_handshake", 64'(hs), 64'd1);
        axi_aw_valid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s, input logic l);
        bit hs = 0;
        int t = 0;
        axi_w_valid = 1'b1;
        axi_w_data = d;
        axi_w_strb = s;
        axi_w_last = l;
        while (!hs && t < 3000) begin
            @(negedge clk);
            hs = axi_w_ready;
            tick();
            t++;
        end
        if (!hs) chk("w_handshake_timeout", 64'(hs), 64'd1);
        axi_w_valid = 1'b0;
    endtask

    task automatic run_burst(input logic [31:0] a, input int len, input logic [2:0] mps,
                             input int pidx, input logic [3:0] pstrb, input int lidx,
                             output logic [1:0] resp);
        logic [31:0] d;
        bit hs = 0;
        int t = 0;
        strbs.delete();
        for (int i = 0; i <= len; i++) strbs.push_back((i == pidx) ? pstrb : 4'hF);
        model(a, len, mps);
        exp_d.delete();
        got_h.delete();
        got_d.delete();
        w_acc = 0;
        send_aw(a, len, mps);
        for (int i = 0; i <= len; i++) begin
            d = $urandom;
            exp_d.push_back(d);
            send_w(d, strbs[i], (i == lidx));
        end
        while (!hs && t < 5000) begin
            @(negedge clk);
            hs = axi_b_valid;
            if (!hs) tick();
            t++;
        end
        chk("b_valid", 64'(hs), 64'd1);
        resp = axi_b_resp;
        chk("b_after_drain", 64'(got_d.size()), 64'(len + 1));
        tick();
        chk("idle_after_b", 64'(axi_aw_ready), 64'd1);
        t = 0;
        while (got_h.size() < exp_h.size() && t < 500) begin
            tick();
            t++;
        end
        chk("hdr_count", 64'(got_h.size()), 64'(exp_h.size()));
        for (int i = 0; i < exp_h.size() && i < got_h.size(); i++)
            chk($sformatf("hdr%0d", i), 64'(pack(got_h[i])), 64'(pack(exp_h[i])));
        chk("data_count", 64'(got_d.size()), 64'(exp_d.size()));
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++)
            chk($sformatf("data%0d", i), 64'(got_d[i]), 64'(exp_d[i]));
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] ra;
        int          rl;
        rst_n = 1'b0;
        axi_aw_valid = 1'b0; axi_aw_addr = '0; axi_aw_len = '0;
        axi_w_valid = 1'b0; axi_w_data = '0; axi_w_strb = 4'hF; axi_w_last = 1'b0;
        axi_b_ready = 1'b1;
        max_payload_size = 3'd0;
        repeat (3) tick();
        chk("rst_aw_ready", 64'(axi_aw_ready), 64'd0);
        chk("rst_w_ready", 64'(axi_w_ready), 64'd0);
        chk("rst_b_valid", 64'(axi_b_valid), 64'd0);
        chk("rst_b_resp", 64'(axi_b_resp), 64'd0);
        chk("rst_h_valid", 64'(wr_tlp_h_valid), 64'd0);
        chk("rst_d_valid", 64'(wr_tlp_d_valid), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("aw_ready_idle", 64'(axi_aw_ready), 64'd1);

        run_burst(32'h0000_1000, 3, 3'd0, -1, 4'hF, 3, resp);
        chk("t1_resp", 64'(resp), 64'd0);
        chk("t1_hdr0", 64'(got_pack(0)), 64'({30'h400, 10'd4, 4'hF, 4'hF}));

        run_burst(32'h0000_0FF8, 3, 3'd0, -1, 4'hF, 3, resp);
        chk("t2_hdr0", 64'(got_pack(0)), 64'({30'h3FE, 10'd2, 4'hF, 4'hF}));
        chk("t2_hdr1", 64'(got_pack(1)), 64'({30'h400, 10'd2, 4'hF, 4'hF}));

        run_burst(32'h0000_0000, 255, 3'd0, -1, 4'hF, 255, resp);
        chk("t3_mps0_count", 64'(got_h.size()), 64'd8);
        chk("t3_mps0_hdr7", 64'(got_pack(7)), 64'({30'd224, 10'd32, 4'hF, 4'hF}));
        run_burst(32'h0000_0000, 255, 3'd2, -1, 4'hF, 255, resp);
        chk("t3_mps2_count", 64'(got_h.size()), 64'd2);
        chk("t3_mps2_hdr1", 64'(got_pack(1)), 64'({30'd128, 10'd128, 4'hF, 4'hF}));

        run_burst(32'h0000_2000, 3, 3'd0, 2, 4'h3, 3, resp);
        chk("t4_hdr0", 64'(got_pack(0)), 64'({30'h800, 10'd2, 4'hF, 4'hF}));
        chk("t4_hdr1", 64'(got_pack(1)), 64'({30'h802, 10'd1, 4'h3, 4'h0}));
        chk("t4_hdr2", 64'(got_pack(2)), 64'({30'h803, 10'd1, 4'hF, 4'h0}));

        stall = 1;
        stall_fill = -1;
        run_burst(32'h0000_0000, 255, 3'd2, -1, 4'hF, 255, resp);
        chk("t5_fill_depth", 64'(stall_fill), 64'(DATA_DEPTH));
        chk("t5_resp", 64'(resp), 64'd0);

        run_burst(32'h0000_4000, 3, 3'd0, -1, 4'hF, 1, resp);
        chk("t6_wlast_resp", 64'(resp), 64'h2);
        run_burst(32'hFFFF_FFF0, 7, 3'd1, -1, 4'hF, 7, resp);
        chk("t6_err_cleared", 64'(resp), 64'd0);

        rnd = 1;
        for (int k = 0; k < 8; k++) begin
            ra = (32'($urandom_range(0, 7)) << 12) | (32'($urandom_range(0, 1023)) << 2);
            rl = $urandom_range(0, 150);
            run_burst(ra, rl, 3'($urandom_range(0, 7)), $urandom_range(0, rl + 3),
                      4'($urandom_range(0, 14)), rl, resp);
            chk("rand_resp", 64'(resp), 64'd0);
        end
        rnd = 0;

        hold = 1;
        tick();
        send_aw(32'h0000_3000, 7, 3'd0);
        send_w(32'h1111_1111, 4'hF, 1'b0);
        send_w(32'h2222_2222, 4'h3, 1'b0);
        send_w(32'h3333_3333, 4'hF, 1'b0);
        tick();
        chk("t7_h_pending", 64'(wr_tlp_h_valid), 64'd1);
        chk("t7_d_pending", 64'(wr_tlp_d_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t7_rst_aw_ready", 64'(axi_aw_ready), 64'd0);
        chk("t7_rst_w_ready", 64'(axi_w_ready), 64'd0);
        chk("t7_rst_b_valid", 64'(axi_b_valid), 64'd0);
        chk("t7_rst_h_valid", 64'(wr_tlp_h_valid), 64'd0);
        chk("t7_rst_d_valid", 64'(wr_tlp_d_valid), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        hold = 0;
        repeat (2) tick();
        chk("t7_post_aw_ready", 64'(axi_aw_ready), 64'd1);
        chk("t7_post_h_valid", 64'(wr_tlp_h_valid), 64'd0);
        chk("t7_post_b_valid", 64'(axi_b_valid), 64'd0);
        run_burst(32'h0000_5000, 5, 3'd0, -1, 4'hF, 5, resp);
        chk("t7_after_resp", 64'(resp), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
